// File: rtl/demux1a16_reg_pkg.sv
// Shared types and sizes for the registered 1-to-16 demultiplexer.
// Mirrors the sizing of the ALU's 16:1 result selector so both sides agree.
package demux1a16_reg_pkg;

  localparam int SEL_W = 4;
  localparam int NBITS = 16;
  localparam int CNT_W = 5;

  // Sweep count value on the 16th write; cnt has one spare bit so 16 never aliases to 0.
  localparam logic [CNT_W-1:0] LAST_CNT = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/demux1a16_reg_if.sv
// Bus bundle for demux1a16_reg: write-side controls in, collected word and status out.
// The master side drives writes; the slave side is the demultiplexer itself.
interface demux1a16_reg_if;
  import demux1a16_reg_pkg::*;

  logic             wr_en;
  logic [SEL_W-1:0] op;
  logic             d;
  logic             start;
  logic             clr;
  logic [NBITS-1:0] r;
  logic [NBITS-1:0] onehot;
  logic             busy;
  logic             done;
  logic [SEL_W-1:0] idx;

  modport master (
    output wr_en, op, d, start, clr,
    input  r, onehot, busy, done, idx
  );

  modport slave (
    input  wr_en, op, d, start, clr,
    output r, onehot, busy, done, idx
  );

endinterface

// File: rtl/demux1a16_reg_dec4a16.sv
// Combinational 4-to-16 one-hot decoder; the exact inverse of the 16:1 bit selector.
module dec4a16
  import demux1a16_reg_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  output logic [NBITS-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/demux1a16_reg.sv
// Registered 1-to-16 demultiplexer: steers one data bit into a held 16-bit word,
// either at an addressed position or across a 16-write sweep from a start index.
module demux1a16_reg
  import demux1a16_reg_pkg::*;
#(
  parameter logic [NBITS-1:0] RESET_VAL = 16'h0000
)
(
  input  logic            clk,
  input  logic            rst_n,
  demux1a16_reg_if.slave  bus
);

  state_t           state_q, state_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [NBITS-1:0] onehot_q, onehot_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel;
  logic [NBITS-1:0] bitEn;
  logic             we;

  // In a sweep the target comes from the running index, otherwise from op.
  assign sel = (state_q == ST_SWEEP) ? idx_q : bus.op;

  dec4a16 u_dec (
    .sel_i    (sel),
    .onehot_o (bitEn)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.clr && bus.start) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (bus.clr) begin
          state_d = ST_IDLE;
        end else if (bus.wr_en && (cnt_q == LAST_CNT)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Priority is clr, then start, then wr_en; DONE swallows writes and starts.
  always_comb begin
    r_d   = r_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    if (bus.clr) begin
      r_d = RESET_VAL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            idx_d = bus.op;
            cnt_d = '0;
          end else begin
            we = bus.wr_en;
          end
        end
        ST_SWEEP: begin
          we = bus.wr_en;
          if (bus.wr_en) begin
            idx_d = idx_q + 4'd1;
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: we = 1'b0;
      endcase
      if (we) begin
        r_d = (r_q & ~bitEn) | (bitEn & {NBITS{bus.d}});
      end
    end
    onehot_d = we ? bitEn : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= RESET_VAL;
      onehot_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      r_q      <= r_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.r      = r_q;
  assign bus.onehot = onehot_q;
  assign bus.idx    = idx_q;
  assign bus.busy   = (state_q == ST_SWEEP);
  assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_demux1a16_reg.sv
// Scoreboard bench for demux1a16_reg: a behavioural model queues the expected
// outputs per cycle and an independent monitor compares them after each edge.
module tb_demux1a16_reg;
  import demux1a16_reg_pkg::*;

  localparam logic [15:0] RST_VAL = 16'h0000;

  typedef struct {
    logic [15:0] r;
    logic [15:0] onehot;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  // Model state: the word, writes still owed by a sweep, sweep position, done pending.
  logic [15:0] mR = RST_VAL;
  int          mLeft = 0;
  int          mPos = 0;
  bit          mDone = 1'b0;

  demux1a16_reg_if bus();

  demux1a16_reg #(.RESET_VAL(RST_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input bit wr, input int op, input bit d, input bit st, input bit cl);
    exp_t e;
    logic [15:0] oh;
    oh = '0;
    if (mDone) begin
      mDone = 1'b0;
      if (cl) mR = RST_VAL;
    end else if (cl) begin
      mR    = RST_VAL;
      mLeft = 0;
    end else if (mLeft == 0) begin
      if (st) begin
        mLeft = 16;
        mPos  = op;
      end else if (wr) begin
        mR[op] = d;
        oh     = 16'(1) << op;
      end
    end else if (wr) begin
      mR[mPos] = d;
      oh       = 16'(1) << mPos;
      mPos     = (mPos + 1) % 16;
      mLeft--;
      if (mLeft == 0) mDone = 1'b1;
    end
    e.r      = mR;
    e.onehot = oh;
    e.busy   = (mLeft > 0);
    e.done   = mDone;
    e.idx    = 4'(mPos);
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit wr, input int op, input bit d, input bit st, input bit cl);
    @(negedge clk);
    bus.wr_en = wr;
    bus.op    = 4'(op);
    bus.d     = d;
    bus.start = st;
    bus.clr   = cl;
    modelStep(wr, op, d, st, cl);
  endtask

  // Reset is asserted mid-high-phase and checked before any further clock edge.
  task automatic asyncReset();
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    #1;
    checkOutput("rst R", bus.r, RST_VAL);
    checkOutput("rst onehot", bus.onehot, 16'h0000);
    checkOutput("rst busy", 16'(bus.busy), 16'h0000);
    checkOutput("rst done", 16'(bus.done), 16'h0000);
    checkOutput("rst idx", 16'(bus.idx), 16'h0000);
    mR    = RST_VAL;
    mLeft = 0;
    mPos  = 0;
    mDone = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("R", bus.r, e.r);
        checkOutput("onehot", bus.onehot, e.onehot);
        checkOutput("busy", 16'(bus.busy), 16'(e.busy));
        checkOutput("done", 16'(bus.done), 16'(e.done));
        checkOutput("idx", 16'(bus.idx), 16'(e.idx));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus.wr_en = 1'b0;
    bus.op    = '0;
    bus.d     = 1'b0;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill R with ones, then reset asynchronously.
    for (int i = 0; i < 16; i++) applyStimulus(1, i, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    asyncReset();

    // Addressed writes, including clearing a bit already set.
    applyStimulus(1, 15, 1, 0, 0);
    applyStimulus(1, 3, 1, 0, 0);
    applyStimulus(1, 15, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Wrapping sweep from 14 with alternating data.
    applyStimulus(0, 14, 0, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, (i % 2) == 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Sweep with a 3-cycle stall after the 5th write.
    applyStimulus(0, 5, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, i[0], 0, 0);
      if (i == 4) repeat (3) applyStimulus(0, 9, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);

    // start+wr_en together, then clr+wr_en after 7 writes aborts.
    applyStimulus(1, 2, 1, 1, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);

    // start ignored while busy and in DONE; wr_en ignored in DONE.
    applyStimulus(0, 7, 0, 1, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 12, 1, (i == 3), 0);
    applyStimulus(1, 4, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Reset in the middle of a sweep must not produce done.
    applyStimulus(0, 9, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 0, 0);
    asyncReset();
    repeat (3) applyStimulus(0, 0, 0, 0, 0);

    // Randomized traffic with occasional clr and start.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 4) != 0, int'($urandom % 16), 1'($urandom),
                    ($urandom % 10) == 0, ($urandom % 40) == 0);
    end
    applyStimulus(0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    if (expQ.size() != 0) begin
      checkOutput("queue drained", 16'(expQ.size()), 16'h0000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
